// File: rtl/pipe_reg_elastic_pkg.sv
// Shared count type and occupancy constants for the elastic pipeline register.
// Latency: none (types/functions only). Backpressure: not applicable.
package pipe_pkg;

  typedef logic [1:0] pipe_cnt_t;

  localparam pipe_cnt_t PIPE_CNT_EMPTY = 2'd0;
  localparam pipe_cnt_t PIPE_CNT_ONE   = 2'd1;
  localparam pipe_cnt_t PIPE_CNT_FULL  = 2'd2;

  function automatic pipe_cnt_t pipe_cnt(input logic main_vld, input logic skid_vld);
    return pipe_cnt_t'({1'b0, main_vld} + {1'b0, skid_vld});
  endfunction

endpackage

// File: rtl/pipe_reg_elastic_entry.sv
// One payload register plus valid bit; reset > clear > load > kill.
// Latency: 1 cycle from load to vld. Backpressure: none, caller decides load/kill.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             kill,
  input  logic [WIDTH-1:0] load_dat,
  output logic             vld,
  output logic [WIDTH-1:0] dat
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (clear) begin
      vld_d = 1'b0;
      if (CLEAR_DATA) dat_d = '0;
    end else if (load) begin
      vld_d = 1'b1;
      dat_d = load_dat;
    end else if (kill) begin
      vld_d = 1'b0;
    end
  end

  // With CLEAR_DATA=0 the data register simply holds through reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      if (CLEAR_DATA) dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld = vld_q;
  assign dat = dat_q;

endmodule

// File: rtl/pipe_reg_elastic.sv
// Elastic valid/ready pipeline register; PIPE_SKID_EN adds a skid entry (registered in_ready).
// Latency: 1 cycle when empty. Backpressure: single-entry mode passes out_ready to in_ready combinationally.
module pipe_reg_elastic
  import pipe_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output pipe_cnt_t        count
);

  logic             main_vld;
  logic [WIDTH-1:0] main_dat;
  logic             main_load;
  logic             main_kill;
  logic [WIDTH-1:0] main_load_dat;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = main_vld && out_ready;
  assign out_valid = main_vld;
  assign out_data  = main_dat;

`ifdef PIPE_SKID_EN
  logic             skid_vld;
  logic [WIDTH-1:0] skid_dat;
  logic             skid_load;
  logic             skid_kill;

  // skid_vld is a flop, so in_ready never sees out_ready within the cycle.
  assign in_ready = !skid_vld && !reset;

  always_comb begin
    main_load     = (in_xfer && (!main_vld || out_xfer)) || (skid_vld && out_xfer);
    main_load_dat = skid_vld ? skid_dat : in_data;
    main_kill     = out_xfer;
    skid_load     = in_xfer && main_vld && !out_xfer;
    skid_kill     = skid_vld && out_xfer;
  end

  pipe_entry #(
    .WIDTH      (WIDTH),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .load     (skid_load),
    .kill     (skid_kill),
    .load_dat (in_data),
    .vld      (skid_vld),
    .dat      (skid_dat)
  );

  assign count = pipe_cnt(main_vld, skid_vld);
`else
  assign in_ready = !reset && (!main_vld || out_ready);

  always_comb begin
    main_load     = in_xfer;
    main_load_dat = in_data;
    main_kill     = out_xfer;
  end

  assign count = pipe_cnt(main_vld, 1'b0);
`endif

  pipe_entry #(
    .WIDTH      (WIDTH),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_main (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .load     (main_load),
    .kill     (main_kill),
    .load_dat (main_load_dat),
    .vld      (main_vld),
    .dat      (main_dat)
  );

endmodule
